// File: rtl/decode_stage.sv
// Registered instruction decoder: immediate, control bits, ALU select, register indices, illegal flag.
// Latency: 1 cycle from accepted instruction to out_valid; one bundle held in the output register.
// Backpressure: in_ready = !flush && (!out_valid || out_ready); the bundle holds stable while stalled.
//
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   in_valid/in_ready            instruction intake handshake (in_instr, in_pc)
//   flush                        drops the held bundle and blocks intake for this cycle
//   out_valid/out_ready          decoded bundle handshake (out_pc, out_imm, indices, controls, alu, illegal)
//   illegal_cnt                  saturating count of accepted illegal instructions
module decode_stage #(
  parameter int XLEN        = 32,
  parameter int IMM_SHIFTED = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_reg_write,
  output logic             out_alu_src,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic             out_branch,
  output logic             out_branch_ne,
  output logic             out_jal,
  output logic             out_jalr,
  output logic             out_lui,
  output logic             out_auipc,
  output logic [3:0]       out_alu_ctl,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_NONE = 4'd15;

  typedef struct packed {
    logic reg_write;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic branch_ne;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } ctl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    ctl_t            ctl;
    logic [3:0]      alu;
    logic            illegal;
  } bundle_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [4:0]      f3_alu;   // {supported, alu select} for the shared R/I funct3 map
  bundle_t         dec;
  bundle_t         q;
  logic            load;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Size casts of signed operands sign-extend to XLEN.
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));

  // Halfword-scaled form drops the always-zero bit0, which equals an arithmetic shift right by one.
  generate
    if (IMM_SHIFTED != 0) begin : g_imm_half
      assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]}));
      assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]}));
    end else begin : g_imm_byte
      assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
      assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    end
  endgenerate

  always_comb begin
    f3_alu = {1'b0, ALU_NONE};
    case (funct3)
      3'b000:  f3_alu = {1'b1, ALU_ADD};
      3'b111:  f3_alu = {1'b1, ALU_AND};
      3'b110:  f3_alu = {1'b1, ALU_OR};
      3'b100:  f3_alu = {1'b1, ALU_XOR};
      3'b010:  f3_alu = {1'b1, ALU_SLT};
      default: f3_alu = {1'b0, ALU_NONE};
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.alu     = ALU_NONE;
    case (opcode)
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          dec.ctl.reg_write  = 1'b1;
          dec.ctl.alu_src    = 1'b1;
          dec.ctl.mem_read   = 1'b1;
          dec.ctl.mem_to_reg = 1'b1;
          dec.alu            = ALU_ADD;
          dec.imm            = imm_i;
        end else dec.illegal = 1'b1;
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          dec.ctl.alu_src   = 1'b1;
          dec.ctl.mem_write = 1'b1;
          dec.alu           = ALU_ADD;
          dec.imm           = imm_s;
        end else dec.illegal = 1'b1;
      end
      OP_REG: begin
        dec.ctl.reg_write = 1'b1;
        if (funct7 == 7'b0000000 && f3_alu[4]) dec.alu = f3_alu[3:0];
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec.alu = ALU_SUB;
        else dec.illegal = 1'b1;
      end
      OP_IMM: begin
        if (f3_alu[4]) begin
          dec.ctl.reg_write = 1'b1;
          dec.ctl.alu_src   = 1'b1;
          dec.alu           = f3_alu[3:0];
          dec.imm           = imm_i;
        end else dec.illegal = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3[2:1] == 2'b00) begin
          dec.ctl.branch    = 1'b1;
          dec.ctl.branch_ne = funct3[0];
          dec.alu           = ALU_SUB;
          dec.imm           = imm_b;
        end else dec.illegal = 1'b1;
      end
      OP_JAL: begin
        dec.ctl.reg_write = 1'b1;
        dec.ctl.jal       = 1'b1;
        dec.imm           = imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          dec.ctl.reg_write = 1'b1;
          dec.ctl.alu_src   = 1'b1;
          dec.ctl.jalr      = 1'b1;
          dec.alu           = ALU_ADD;
          dec.imm           = imm_i;
        end else dec.illegal = 1'b1;
      end
      OP_LUI: begin
        dec.ctl.reg_write = 1'b1;
        dec.ctl.lui       = 1'b1;
        dec.imm           = imm_u;
      end
      OP_AUIPC: begin
        dec.ctl.reg_write = 1'b1;
        dec.ctl.auipc     = 1'b1;
        dec.alu           = ALU_ADD;
        dec.imm           = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal bundles carry no side effects downstream.
    if (dec.illegal) begin
      dec.ctl = '0;
      dec.alu = ALU_NONE;
      dec.imm = '0;
    end
  end

  assign in_ready = !flush && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      q           <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      q         <= dec;
      if (dec.illegal && illegal_cnt != {CNT_W{1'b1}})
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc         = q.pc;
  assign out_imm        = q.imm;
  assign out_rd         = q.rd;
  assign out_rs1        = q.rs1;
  assign out_rs2        = q.rs2;
  assign out_reg_write  = q.ctl.reg_write;
  assign out_alu_src    = q.ctl.alu_src;
  assign out_mem_read   = q.ctl.mem_read;
  assign out_mem_write  = q.ctl.mem_write;
  assign out_mem_to_reg = q.ctl.mem_to_reg;
  assign out_branch     = q.ctl.branch;
  assign out_branch_ne  = q.ctl.branch_ne;
  assign out_jal        = q.ctl.jal;
  assign out_jalr       = q.ctl.jalr;
  assign out_lui        = q.ctl.lui;
  assign out_auipc      = q.ctl.auipc;
  assign out_alu_ctl    = q.alu;
  assign out_illegal    = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: three instances (32-bit byte offsets, 32-bit halfword offsets with
// a 2-bit counter, 64-bit) share one stimulus stream and are compared against a reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // instance a: XLEN=32, byte offsets, CNT_W=16
  logic a_ir, a_ov, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0] a_rd, a_rs1, a_rs2;
  logic [10:0] a_ctl;
  logic [3:0] a_alu;
  logic [15:0] a_cnt;
  // instance s: XLEN=32, halfword offsets, CNT_W=2
  logic s_ir, s_ov, s_ill;
  logic [31:0] s_pc, s_imm;
  logic [4:0] s_rd, s_rs1, s_rs2;
  logic [10:0] s_ctl;
  logic [3:0] s_alu;
  logic [1:0] s_cnt;
  // instance w: XLEN=64, byte offsets, CNT_W=16
  logic w_ir, w_ov, w_ill;
  logic [63:0] w_pc, w_imm;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic [10:0] w_ctl;
  logic [3:0] w_alu;
  logic [15:0] w_cnt;

  decode_stage #(.XLEN(32), .IMM_SHIFTED(0), .CNT_W(16)) u_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(a_ir), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .flush(flush), .out_valid(a_ov), .out_ready(out_ready),
    .out_pc(a_pc), .out_imm(a_imm), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_reg_write(a_ctl[10]), .out_alu_src(a_ctl[9]), .out_mem_read(a_ctl[8]),
    .out_mem_write(a_ctl[7]), .out_mem_to_reg(a_ctl[6]), .out_branch(a_ctl[5]),
    .out_branch_ne(a_ctl[4]), .out_jal(a_ctl[3]), .out_jalr(a_ctl[2]), .out_lui(a_ctl[1]),
    .out_auipc(a_ctl[0]), .out_alu_ctl(a_alu), .out_illegal(a_ill), .illegal_cnt(a_cnt));

  decode_stage #(.XLEN(32), .IMM_SHIFTED(1), .CNT_W(2)) u_s (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(s_ir), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .flush(flush), .out_valid(s_ov), .out_ready(out_ready),
    .out_pc(s_pc), .out_imm(s_imm), .out_rd(s_rd), .out_rs1(s_rs1), .out_rs2(s_rs2),
    .out_reg_write(s_ctl[10]), .out_alu_src(s_ctl[9]), .out_mem_read(s_ctl[8]),
    .out_mem_write(s_ctl[7]), .out_mem_to_reg(s_ctl[6]), .out_branch(s_ctl[5]),
    .out_branch_ne(s_ctl[4]), .out_jal(s_ctl[3]), .out_jalr(s_ctl[2]), .out_lui(s_ctl[1]),
    .out_auipc(s_ctl[0]), .out_alu_ctl(s_alu), .out_illegal(s_ill), .illegal_cnt(s_cnt));

  decode_stage #(.XLEN(64), .IMM_SHIFTED(0), .CNT_W(16)) u_w (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(w_ir), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(w_ov), .out_ready(out_ready),
    .out_pc(w_pc), .out_imm(w_imm), .out_rd(w_rd), .out_rs1(w_rs1), .out_rs2(w_rs2),
    .out_reg_write(w_ctl[10]), .out_alu_src(w_ctl[9]), .out_mem_read(w_ctl[8]),
    .out_mem_write(w_ctl[7]), .out_mem_to_reg(w_ctl[6]), .out_branch(w_ctl[5]),
    .out_branch_ne(w_ctl[4]), .out_jal(w_ctl[3]), .out_jalr(w_ctl[2]), .out_lui(w_ctl[1]),
    .out_auipc(w_ctl[0]), .out_alu_ctl(w_alu), .out_illegal(w_ill), .illegal_cnt(w_cnt));

  wire [158:0] o_a = {32'b0, a_pc, 32'b0, a_imm, a_rd, a_rs1, a_rs2, a_ctl, a_alu, a_ill};
  wire [158:0] o_s = {32'b0, s_pc, 32'b0, s_imm, s_rd, s_rs1, s_rs2, s_ctl, s_alu, s_ill};
  wire [158:0] o_w = {w_pc, w_imm, w_rd, w_rs1, w_rs2, w_ctl, w_alu, w_ill};

  // Reference decode. Control order: reg_write alu_src mem_read mem_write mem_to_reg
  // branch branch_ne jal jalr lui auipc. Offsets are computed as signed integers.
  function automatic logic [158:0] ref_bundle(input logic [31:0] i, input logic [63:0] pc,
                                              input bit wide, input bit halfword);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    longint imm;
    int alu;
    int fa;
    bit ill;
    logic [10:0] c;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    imm = 0; alu = 15; ill = 0; c = '0;
    case (f3)
      3'b000: fa = 2;
      3'b111: fa = 0;
      3'b110: fa = 1;
      3'b100: fa = 3;
      3'b010: fa = 7;
      default: fa = -1;
    endcase
    case (op)
      7'h03: if (f3 == 2) begin c = 11'b11101000000; alu = 2; imm = longint'($signed(i[31:20])); end else ill = 1;
      7'h23: if (f3 == 2) begin c = 11'b01010000000; alu = 2; imm = longint'($signed({i[31:25], i[11:7]})); end else ill = 1;
      7'h33: begin
        if (f7 == 0 && fa >= 0) begin c = 11'b10000000000; alu = fa; end
        else if (f7 == 7'h20 && f3 == 0) begin c = 11'b10000000000; alu = 6; end
        else ill = 1;
      end
      7'h13: if (fa >= 0) begin c = 11'b11000000000; alu = fa; imm = longint'($signed(i[31:20])); end else ill = 1;
      7'h63: begin
        if (f3 == 0 || f3 == 1) begin
          c = (f3 == 1) ? 11'b00000110000 : 11'b00000100000;
          alu = 6;
          imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
          if (halfword) imm = imm / 2;
        end else ill = 1;
      end
      7'h6F: begin
        c = 11'b10000001000; alu = 15;
        imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        if (halfword) imm = imm / 2;
      end
      7'h67: if (f3 == 0) begin c = 11'b11000000100; alu = 2; imm = longint'($signed(i[31:20])); end else ill = 1;
      7'h37: begin c = 11'b10000000010; alu = 15; imm = longint'($signed({i[31:12], 12'b0})); end
      7'h17: begin c = 11'b10000000001; alu = 2; imm = longint'($signed({i[31:12], 12'b0})); end
      default: ill = 1;
    endcase
    if (ill) begin c = '0; alu = 15; imm = 0; end
    if (wide) return {pc, imm[63:0], i[11:7], i[19:15], i[24:20], c, alu[3:0], ill};
    return {32'b0, pc[31:0], 32'b0, imm[31:0], i[11:7], i[19:15], i[24:20], c, alu[3:0], ill};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] i;
    logic [6:0] ops [0:8];
    logic [2:0] good [0:4];
    int k;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    good = '{3'd0, 3'd7, 3'd6, 3'd4, 3'd2};
    i = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) i[6:0] = ops[k];
    if ($urandom_range(0, 3) != 0) begin
      case (i[6:0])
        7'h03, 7'h23: i[14:12] = 3'd2;
        7'h63: i[14:12] = 3'($urandom_range(0, 1));
        7'h67: i[14:12] = 3'd0;
        7'h33, 7'h13: begin
          i[14:12] = good[$urandom_range(0, 4)];
          i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        end
        default: ;
      endcase
    end
    return i;
  endfunction

  // Transaction-level model of the output register and counters.
  logic        m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  int          m_cnt16, m_cnt2;
  wire         m_rdy = !flush && (!m_valid || out_ready);
  wire [158:0] in_ref = ref_bundle(in_instr, in_pc, 1'b0, 1'b0);
  wire [158:0] e_a = ref_bundle(m_instr, m_pc, 1'b0, 1'b0);
  wire [158:0] e_s = ref_bundle(m_instr, m_pc, 1'b0, 1'b1);
  wire [158:0] e_w = ref_bundle(m_instr, m_pc, 1'b1, 1'b0);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0; m_instr <= '0; m_pc <= '0; m_cnt16 <= 0; m_cnt2 <= 0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && m_rdy) begin
      m_valid <= 1'b1; m_instr <= in_instr; m_pc <= in_pc;
      if (in_ref[0]) begin
        m_cnt16 <= (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
        m_cnt2  <= (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    checks++; if ({a_ov, s_ov, w_ov} !== 3'b000) begin errors++; $display("FAIL reset_valid got %b want 000", {a_ov, s_ov, w_ov}); end
    checks++; if ({a_cnt, s_cnt, w_cnt} !== 34'd0) begin errors++; $display("FAIL reset_cnt got %h/%h/%h want 0", a_cnt, s_cnt, w_cnt); end
    checks++; if (o_a !== '0 || o_w !== '0) begin errors++; $display("FAIL reset_bundle got %h / %h want 0", o_a, o_w); end
    checks++; if ({a_ir, s_ir, w_ir} !== 3'b111) begin errors++; $display("FAIL reset_ready got %b want 111", {a_ir, s_ir, w_ir}); end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    in_valid = 1'b1; in_instr = 32'hFFC12283; in_pc = 64'h1000; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL lw_valid got %b want 1", a_ov); end
    checks++; if (a_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL lw_imm got %h want fffffffc", a_imm); end
    checks++; if ({a_rd, a_rs1} !== {5'd5, 5'd2}) begin errors++; $display("FAIL lw_regs got rd=%0d rs1=%0d want 5 2", a_rd, a_rs1); end
    checks++; if ({a_ctl, a_alu} !== {11'b11101000000, 4'd2}) begin errors++; $display("FAIL lw_ctl got %b alu=%0d want 11101000000 alu=2", a_ctl, a_alu); end
    checks++; if (a_pc !== 32'h1000) begin errors++; $display("FAIL lw_pc got %h want 1000", a_pc); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL lw_drain got %b want 0", a_ov); end
    @(posedge clk); #1;
  endtask

  task automatic test_beq();
    in_valid = 1'b1; in_instr = 32'hFE208CE3; in_pc = 64'h2000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_imm !== 32'hFFFFFFF8) begin errors++; $display("FAIL beq_imm got %h want fffffff8", a_imm); end
    checks++; if (s_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm_half got %h want fffffffc", s_imm); end
    checks++; if ({a_ctl, a_alu} !== {11'b00000100000, 4'd6}) begin errors++; $display("FAIL beq_ctl got %b alu=%0d want 00000100000 alu=6", a_ctl, a_alu); end
    @(posedge clk); #1;
  endtask

  task automatic test_lui64();
    in_valid = 1'b1; in_instr = 32'h800000B7; in_pc = 64'h8000_0000_0000_0004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (w_imm !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL lui64_imm got %h want ffffffff80000000", w_imm); end
    checks++; if ({w_ctl, w_rd, w_alu} !== {11'b10000000010, 5'd1, 4'd15}) begin errors++; $display("FAIL lui64_ctl got %b rd=%0d alu=%0d", w_ctl, w_rd, w_alu); end
    checks++; if (w_pc !== 64'h8000_0000_0000_0004) begin errors++; $display("FAIL lui64_pc got %h", w_pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] got [$];
    in_valid = 1'b1; in_instr = 32'h002081B3; out_ready = 1'b1;
    @(posedge clk); #1;
    in_instr = 32'h402081B3; out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++; if ({a_ov, a_ir, a_alu} !== {1'b1, 1'b0, 4'd2}) begin errors++; $display("FAIL stall_hold cyc %0d got v=%b rdy=%b alu=%0d want 1 0 2", n, a_ov, a_ir, a_alu); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (a_ov && out_ready) got.push_back(a_alu);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", got.size()); end
    else begin
      checks++; if (got[0] !== 4'd2 || got[1] !== 4'd6) begin errors++; $display("FAIL b2b_order got %0d,%0d want 2,6", got[0], got[1]); end
    end
  endtask

  task automatic test_flush();
    logic [15:0] cnt0;
    in_valid = 1'b1; in_instr = 32'hFFC12283; out_ready = 1'b0;
    @(posedge clk); #1;
    cnt0 = a_cnt;
    in_instr = 32'h0; flush = 1'b1;
    @(negedge clk);
    checks++; if ({a_ir, a_ov} !== 2'b01) begin errors++; $display("FAIL flush_pulse got rdy=%b v=%b want 0 1", a_ir, a_ov); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL flush_clear got %b want 0", a_ov); end
    checks++; if (a_cnt !== cnt0) begin errors++; $display("FAIL flush_cnt got %0d want %0d", a_cnt, cnt0); end
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 32'h002081B3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({a_ov, a_ctl, a_alu, a_ill} !== {1'b1, 11'b10000000000, 4'd2, 1'b0}) begin errors++; $display("FAIL flush_next got v=%b ctl=%b alu=%0d ill=%b", a_ov, a_ctl, a_alu, a_ill); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = gen_instr();
      in_pc     = {$urandom, $urandom};
      @(negedge clk);
      checks++; if ({a_ir, s_ir, w_ir} !== {3{m_rdy}}) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", n, {a_ir, s_ir, w_ir}, {3{m_rdy}}); end
      checks++; if ({a_ov, s_ov, w_ov} !== {3{m_valid}}) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", n, {a_ov, s_ov, w_ov}, {3{m_valid}}); end
      if (m_valid) begin
        checks++; if (o_a !== e_a) begin errors++; $display("FAIL rnd_bundle_a cyc %0d instr %h got %h want %h", n, m_instr, o_a, e_a); end
        checks++; if (o_s !== e_s) begin errors++; $display("FAIL rnd_bundle_s cyc %0d instr %h got %h want %h", n, m_instr, o_s, e_s); end
        checks++; if (o_w !== e_w) begin errors++; $display("FAIL rnd_bundle_w cyc %0d instr %h got %h want %h", n, m_instr, o_w, e_w); end
      end
      checks++; if (a_cnt !== 16'(m_cnt16) || w_cnt !== 16'(m_cnt16) || s_cnt !== 2'(m_cnt2)) begin
        errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d/%0d want %0d/%0d", n, a_cnt, w_cnt, s_cnt, m_cnt16, m_cnt2);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    rstn = 1'b0; #2; rstn = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0; out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({s_ov, s_ill, s_ctl, s_alu, s_imm} !== {1'b1, 1'b1, 11'b0, 4'd15, 32'd0}) begin errors++; $display("FAIL illegal_bundle %0d got v=%b ill=%b ctl=%b alu=%0d imm=%h", k, s_ov, s_ill, s_ctl, s_alu, s_imm); end
      checks++; if (s_cnt !== 2'((k > 3) ? 3 : k)) begin errors++; $display("FAIL illegal_sat %0d got %0d want %0d", k, s_cnt, (k > 3) ? 3 : k); end
      checks++; if (a_cnt !== 16'(k)) begin errors++; $display("FAIL illegal_cnt16 %0d got %0d want %0d", k, a_cnt, k); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_instr = 32'hFFC12283; in_pc = 64'h3000; out_ready = 1'b0;
    @(posedge clk); #1;
    in_instr = 32'h002081B3;
    #2 rstn = 1'b0;
    #1;
    checks++; if ({a_ov, s_ov, w_ov} !== 3'b000) begin errors++; $display("FAIL rstmid_valid got %b want 000", {a_ov, s_ov, w_ov}); end
    checks++; if (o_a !== '0 || o_s !== '0 || o_w !== '0) begin errors++; $display("FAIL rstmid_bundle got %h want 0", o_a); end
    checks++; if ({a_cnt, s_cnt, w_cnt} !== 34'd0) begin errors++; $display("FAIL rstmid_cnt got %0d/%0d/%0d want 0", a_cnt, s_cnt, w_cnt); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL rstmid_after got %b want 0", a_ov); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_lui64();
    test_back_to_back();
    test_flush();
    test_random();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
